// File: rtl/spr_pkg.sv
// Shared definitions for the sprite line fetcher: FSM states, attribute byte
// offsets, sprite geometry and sprite ROM address field widths.
package spr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTR,
    S_CHECK,
    S_FETCH,
    S_FWAIT,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] ATTR_Y     = 2'd0;
  localparam logic [1:0] ATTR_CODE  = 2'd1;
  localparam logic [1:0] ATTR_FLAGS = 2'd2;
  localparam logic [1:0] ATTR_X     = 2'd3;

  localparam int SPR_H = 16;
  localparam int SPR_W = 16;

  localparam int ROM_CODE_W = 8;
  localparam int ROM_ROW_W  = 4;
  localparam int ROM_ADDR_W = ROM_CODE_W + ROM_ROW_W + 1;

endpackage

// File: rtl/spr_pix_shift.sv
// Plane shift registers for one 8-pixel half of a sprite row. Loaded from the
// two ROM planes, then shifted one pixel per cycle in flip-aware direction.
module spr_pix_shift (
  input  logic       clk_sys,
  input  logic       load,
  input  logic       shift,
  input  logic       flipx,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  output logic [1:0] pix
);

  logic [7:0] p1_q;
  logic [7:0] p2_q;

  // Capture both planes, then walk MSB-first (or LSB-first when mirrored)
  always_ff @(posedge clk_sys) begin
    if (load) begin
      p1_q <= d1;
      p2_q <= d2;
    end else if (shift) begin
      if (flipx) begin
        p1_q <= p1_q >> 1;
        p2_q <= p2_q >> 1;
      end else begin
        p1_q <= p1_q << 1;
        p2_q <= p2_q << 1;
      end
    end
  end

  assign pix = flipx ? {p2_q[0], p1_q[0]} : {p2_q[7], p1_q[7]};

endmodule

// File: rtl/spr_line_fetch.sv
// Sprite line renderer: scans the attribute RAM for sprites crossing the
// requested scanline, fetches their ROM plane bytes and writes non-zero
// pixels into the external line buffer.
// Optional per-line sprite cap with overflow flag: SPR_LINE_FETCH_OVERFLOW_EN.
module spr_line_fetch
  import spr_pkg::*;
#(
  parameter int NUM_SPR      = 16,
  parameter int MAX_PER_LINE = 8
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [7:0]                  line,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_SPR)+1:0]  attr_addr,
  input  logic [7:0]                  attr_data,
  output logic [ROM_ADDR_W-1:0]       spr_rom_addr,
  input  logic [7:0]                  spr_data1,
  input  logic [7:0]                  spr_data2,
  output logic                        lb_we,
  output logic [7:0]                  lb_addr,
  output logic [4:0]                  lb_data,
  output logic                        overflow
);

  localparam int IDX_W = $clog2(NUM_SPR);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [2:0]          sub_q;
  logic                half_q;
  logic [7:0]          line_q, y_q, code_q, x_q;
  logic                flipy_q, flipx_q;
  logic [2:0]          colour_q;
  logic [7:0]          dy;
  logic                raw_hit, hit_ok;
  logic [ROM_ROW_W-1:0] row;
  logic [8:0]          xsum;
  logic [1:0]          pix;
  logic                unused_bits;

  assign dy          = line_q - y_q;
  assign raw_hit     = (dy[7:4] == 4'd0);
  assign row         = flipy_q ? ~dy[3:0] : dy[3:0];
  assign xsum        = {1'b0, x_q} + {5'd0, half_q, sub_q};
  assign unused_bits = ^attr_data[5:3];

`ifdef SPR_LINE_FETCH_OVERFLOW_EN
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  logic [CNT_W-1:0] hit_cnt_q;
  logic             ovf_q;
  logic             cap;

  assign cap    = (hit_cnt_q == CNT_W'(MAX_PER_LINE));
  assign hit_ok = raw_hit && !cap;

  // Per-line hit budget; a capped hit is dropped and latches overflow
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (state_q == S_CHECK && raw_hit) begin
      if (cap) ovf_q <= 1'b1;
      else     hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  localparam int unused_cap = MAX_PER_LINE;
  assign hit_ok   = raw_hit;
  assign overflow = 1'b0;
`endif

  // Next-state sequencing of the per-sprite scan
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ATTR;
      S_ATTR:  if (sub_q == 3'd4) state_d = S_CHECK;
      S_CHECK: state_d = hit_ok ? S_FETCH : S_NEXT;
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: state_d = S_EMIT;
      S_EMIT:  if (sub_q == 3'd7) state_d = half_q ? S_NEXT : S_FETCH;
      S_NEXT:  state_d = (idx_q == IDX_W'(NUM_SPR - 1)) ? S_DONE : S_ATTR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: state, sprite index, cycle counter and half select
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sub_q   <= 3'd0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE:  if (start) begin
                   idx_q <= '0;
                   sub_q <= 3'd0;
                 end
        S_ATTR:  sub_q <= (sub_q == 3'd4) ? 3'd0 : sub_q + 3'd1;
        S_CHECK: half_q <= 1'b0;
        S_EMIT:  begin
                   sub_q <= sub_q + 3'd1;
                   if (sub_q == 3'd7) half_q <= 1'b1;
                 end
        S_NEXT:  idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Data capture: target line on start, attribute bytes one cycle after address
  always_ff @(posedge clk_sys) begin
    if (state_q == S_IDLE && start) line_q <= line;
    if (state_q == S_ATTR) begin
      case (sub_q)
        3'd1: y_q    <= attr_data;
        3'd2: code_q <= attr_data;
        3'd3: begin
                flipy_q  <= attr_data[7];
                flipx_q  <= attr_data[6];
                colour_q <= attr_data[2:0];
              end
        3'd4: x_q    <= attr_data;
        default: ;
      endcase
    end
  end

  spr_pix_shift u_pix (
    .clk_sys (clk_sys),
    .load    (state_q == S_FWAIT),
    .shift   (state_q == S_EMIT),
    .flipx   (flipx_q),
    .d1      (spr_data1),
    .d2      (spr_data2),
    .pix     (pix)
  );

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign attr_addr    = (state_q == S_ATTR) ? {idx_q, sub_q[1:0]} : '0;
  assign spr_rom_addr = (state_q == S_FETCH) ? {code_q, row, half_q ^ flipx_q} : '0;
  assign lb_we        = (state_q == S_EMIT) && (pix != 2'd0) && !xsum[8];
  assign lb_addr      = (state_q == S_EMIT) ? xsum[7:0] : 8'd0;
  assign lb_data      = (state_q == S_EMIT) ? {colour_q, pix} : 5'd0;

endmodule

// File: tb/tb_spr_line_fetch.sv
// Testbench for spr_line_fetch: table of single-sprite scenarios, randomized
// lines checked against a line-buffer reference model, and hand sequences for
// start-while-busy, start-on-done, capacity/overflow and reset mid-scan.
module tb_spr_line_fetch;

`ifdef SPR_LINE_FETCH_OVERFLOW_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif
  localparam int MAXL = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  line;
  logic        busy, done;
  logic [5:0]  attr_addr;
  logic [7:0]  attr_data;
  logic [12:0] spr_rom_addr;
  logic [7:0]  spr_data1, spr_data2;
  logic        lb_we;
  logic [7:0]  lb_addr;
  logic [4:0]  lb_data;
  logic        overflow;

  spr_line_fetch #(.NUM_SPR(16), .MAX_PER_LINE(MAXL)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .line(line),
    .busy(busy), .done(done), .attr_addr(attr_addr), .attr_data(attr_data),
    .spr_rom_addr(spr_rom_addr), .spr_data1(spr_data1), .spr_data2(spr_data2),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] attr_mem [64];
  logic [7:0] rom1 [8192];
  logic [7:0] rom2 [8192];

  always @(posedge clk_sys) begin
    attr_data <= attr_mem[attr_addr];
    spr_data1 <= rom1[spr_rom_addr];
    spr_data2 <= rom2[spr_rom_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] act_img [256];
  logic [7:0] exp_img [256];
  int act_busy, act_wr, act_done, act_addr0;
  bit act_ovf_first, act_ovf_end, seen_done;

  typedef struct {
    logic [7:0] ln, y, code, flags, x;
    int exp_addr0, exp_busy, exp_wr;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: paint every intersecting sprite into an image, later index wins
  task automatic model(input logic [7:0] ln, output int writes, output int hits,
                       output bit ovf);
    logic [7:0] y, code, fl, xx, dy, b1, b2;
    logic [3:0] row;
    logic [12:0] a;
    logic [1:0] p;
    int src;
    for (int i = 0; i < 256; i++) exp_img[i] = 8'hFF;
    writes = 0; hits = 0; ovf = 1'b0;
    for (int s = 0; s < 16; s++) begin
      y = attr_mem[s*4]; code = attr_mem[s*4+1]; fl = attr_mem[s*4+2]; xx = attr_mem[s*4+3];
      dy = ln - y;
      if (dy >= 8'd16) continue;
      if (CAP_EN && hits == MAXL) begin ovf = 1'b1; continue; end
      hits++;
      row = fl[7] ? 4'(15 - int'(dy)) : dy[3:0];
      for (int c = 0; c < 16; c++) begin
        src = fl[6] ? 15 - c : c;
        a = {code, row, (src >= 8) ? 1'b1 : 1'b0};
        b1 = rom1[a]; b2 = rom2[a];
        p = {b2[7 - src % 8], b1[7 - src % 8]};
        if (p != 2'd0 && int'(xx) + c < 256) begin
          exp_img[int'(xx) + c] = {3'b000, fl[2:0], p};
          writes++;
        end
      end
    end
  endtask

  // Drive one start and observe the whole scan plus a few idle cycles after done
  task automatic run_line(input logic [7:0] ln, input int poke_at,
                          input logic [7:0] poke_ln, input bit poke_done);
    int post;
    for (int i = 0; i < 256; i++) act_img[i] = 8'hFF;
    act_busy = 0; act_wr = 0; act_done = 0; act_addr0 = -1;
    act_ovf_first = 1'b0; act_ovf_end = 1'b0; seen_done = 1'b0; post = 0;
    @(negedge clk_sys); start = 1'b1; line = ln;
    @(negedge clk_sys);
    for (int cyc = 0; cyc < 1200; cyc++) begin
      start = 1'b0;
      if (cyc == 0) act_ovf_first = overflow;
      if (lb_we) begin act_img[lb_addr] = {3'b000, lb_data}; act_wr++; end
      if (busy) act_busy++;
      if (spr_rom_addr != 13'd0 && act_addr0 < 0) act_addr0 = int'(spr_rom_addr);
      if (done) begin
        act_done++;
        if (!seen_done) begin
          seen_done = 1'b1;
          act_ovf_end = overflow;
          if (poke_done) begin start = 1'b1; line = poke_ln; end
        end
      end
      if (cyc == poke_at) begin start = 1'b1; line = poke_ln; end
      if (seen_done) post++;
      if (post == 6) break;
      @(negedge clk_sys);
    end
    start = 1'b0;
    chk("done_seen", int'(seen_done), 1);
  endtask

  task automatic check_image(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 256; i++)
      if (act_img[i] != exp_img[i]) begin bad++; if (first < 0) first = i; end
    n_vec++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s image: %0d pixels differ, first x=%0d got 0x%0h want 0x%0h",
               name, bad, first, act_img[first], exp_img[first]);
    end
  endtask

  task automatic run_and_check(input string name, input logic [7:0] ln, input int poke_at,
                               input logic [7:0] poke_ln, input bit poke_done);
    int ew, eh;
    bit eo;
    model(ln, ew, eh, eo);
    run_line(ln, poke_at, poke_ln, poke_done);
    check_image(name);
    chk({name, " writes"}, act_wr, ew);
    chk({name, " busy"}, act_busy, 112 + 20 * eh);
    chk({name, " done_pulses"}, act_done, 1);
    chk({name, " ovf_first"}, int'(act_ovf_first), 0);
    chk({name, " ovf_end"}, int'(act_ovf_end), int'(eo));
  endtask

  task automatic fill_miss(input logic [7:0] ln);
    for (int s = 0; s < 16; s++) begin
      attr_mem[s*4] = ln + 8'd32; attr_mem[s*4+1] = 8'd0;
      attr_mem[s*4+2] = 8'd0;     attr_mem[s*4+3] = 8'd0;
    end
  endtask

  initial begin
    int ew, eh, cnt;
    bit eo;
    reset_n = 1'b0; start = 1'b0; line = 8'd0;
    for (int i = 0; i < 64; i++) attr_mem[i] = 8'd0;
    for (int i = 0; i < 8192; i++) begin rom1[i] = 8'd0; rom2[i] = 8'd0; end
    rom1[13'h0A4] = 8'hF0; rom2[13'h0A4] = 8'h0F;
    rom1[13'h0A5] = 8'h81; rom2[13'h0A5] = 8'h00;
    rom1[13'h0BB] = 8'h01; rom2[13'h0BA] = 8'h80;
    rom1[13'h0B4] = 8'hAA;

    vecs[0] = '{8'd12, 8'd10,  8'h05, 8'h03, 8'd100, 'h0A4, 132, 10};
    vecs[1] = '{8'd12, 8'd10,  8'h05, 8'hC3, 8'd100, 'h0BB, 132, 2};
    vecs[2] = '{8'd12, 8'd10,  8'h05, 8'h03, 8'd250, 'h0A4, 132, 6};
    vecs[3] = '{8'd4,  8'd250, 8'h05, 8'h03, 8'd100, 'h0B4, 132, 4};
    vecs[4] = '{8'd16, 8'd0,   8'h05, 8'h03, 8'd100, -1,    112, 0};
    vecs[5] = '{8'd25, 8'd10,  8'h05, 8'h03, 8'd100, 'h0BE, 132, 0};
    vecs[6] = '{8'd26, 8'd10,  8'h05, 8'h03, 8'd100, -1,    112, 0};
    vecs[7] = '{8'd9,  8'd10,  8'h05, 8'h03, 8'd100, -1,    112, 0};
    vecs[8] = '{8'd12, 8'd10,  8'h05, 8'h43, 8'd100, 'h0A5, 132, 10};

    repeat (3) @(negedge clk_sys);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst lb_we", int'(lb_we), 0);
    chk("rst addrs", int'({attr_addr, spr_rom_addr, lb_addr, lb_data}), 0);
    chk("rst overflow", int'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Table-driven single-sprite scenarios (sprite at index 5, others miss)
    for (int v = 0; v < 9; v++) begin
      fill_miss(vecs[v].ln);
      attr_mem[20] = vecs[v].y;     attr_mem[21] = vecs[v].code;
      attr_mem[22] = vecs[v].flags; attr_mem[23] = vecs[v].x;
      model(vecs[v].ln, ew, eh, eo);
      run_line(vecs[v].ln, -1, 8'd0, 1'b0);
      chk($sformatf("vec%0d busy", v), act_busy, vecs[v].exp_busy);
      chk($sformatf("vec%0d writes", v), act_wr, vecs[v].exp_wr);
      chk($sformatf("vec%0d addr0", v), act_addr0, vecs[v].exp_addr0);
      chk($sformatf("vec%0d done_pulses", v), act_done, 1);
      check_image($sformatf("vec%0d", v));
    end

    // Start while busy and start coinciding with done are both ignored
    fill_miss(8'd12);
    attr_mem[20] = 8'd10; attr_mem[21] = 8'h05; attr_mem[22] = 8'h03; attr_mem[23] = 8'd100;
    run_and_check("poke", 8'd12, 10, 8'd200, 1'b1);

    // Random attribute tables and ROM contents against the model
    for (int i = 0; i < 8192; i++) begin rom1[i] = 8'($urandom); rom2[i] = 8'($urandom); end
    for (int r = 0; r < 12; r++) begin
      logic [7:0] ln;
      ln = 8'($urandom);
      for (int s = 0; s < 16; s++) begin
        attr_mem[s*4]   = ln - 8'($urandom_range(0, 24));
        attr_mem[s*4+1] = 8'($urandom);
        attr_mem[s*4+2] = 8'($urandom);
        attr_mem[s*4+3] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(236, 255)) : 8'($urandom);
      end
      run_and_check($sformatf("rnd%0d", r), ln, -1, 8'd0, 1'b0);
    end

    // Ten sprites on one line: capacity and overflow, then cleared by next start
    fill_miss(8'd50);
    for (int s = 0; s < 10; s++) begin
      attr_mem[s*4] = 8'(50 - s); attr_mem[s*4+1] = 8'(s + 1);
      attr_mem[s*4+2] = 8'($urandom); attr_mem[s*4+3] = 8'(s * 20);
    end
    run_and_check("cap", 8'd50, -1, 8'd0, 1'b0);
    fill_miss(8'd70);
    run_and_check("cap_clear", 8'd70, -1, 8'd0, 1'b0);

    // Reset mid-scan aborts at once with no further writes
    fill_miss(8'd12);
    attr_mem[20] = 8'd10; attr_mem[21] = 8'h05; attr_mem[22] = 8'h03; attr_mem[23] = 8'd100;
    @(negedge clk_sys); start = 1'b1; line = 8'd12;
    @(negedge clk_sys); start = 1'b0;
    cnt = 0;
    while (!lb_we && cnt < 300) begin @(negedge clk_sys); cnt++; end
    chk("midrst reached_emit", int'(lb_we), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst lb_we", int'(lb_we), 0);
    chk("midrst busy", int'(busy), 0);
    cnt = 0;
    repeat (5) begin @(negedge clk_sys); if (lb_we || busy) cnt++; end
    reset_n = 1'b1;
    repeat (40) begin @(negedge clk_sys); if (lb_we || busy || done) cnt++; end
    chk("midrst quiet", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spr_line_fetch.md
Name: spr_line_fetch

Overview:
- Sprite line renderer and read-side client of the two sprite graphics ROM planes.
- Once per scanline, after a start pulse, it walks the sprite attribute RAM and selects sprites that intersect the requested line.
- For each selected sprite it reads plane-1/plane-2 bytes over the shared 13-bit sprite ROM address bus (1-cycle read latency).
- It writes 2bpp+colour pixels into an external line buffer. It sits between video timing and the line buffer.

Parameters:
- NUM_SPR, 16, number of sprite entries scanned per line (4 attribute bytes each).
- MAX_PER_LINE, 8, per-line sprite cap; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin rendering line `line`.
- line  in  8  target scanline, sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the scan finishes.
- attr_addr  out  $clog2(NUM_SPR)+2  attribute RAM byte address {index, byte}.
- attr_data  in  8  attribute byte; valid 1 cycle after attr_addr.
- spr_rom_addr  out  13  {code[7:0], row[3:0], half}.
- spr_data1  in  8  plane-1 byte; valid 1 cycle after address.
- spr_data2  in  8  plane-2 byte; valid 1 cycle after address.
- lb_we  out  1  line-buffer write strobe.
- lb_addr  out  8  line-buffer x.
- lb_data  out  5  {colour[2:0], pix[1:0]}.
- overflow  out  1  per-line overflow flag (feature only; tied 0 otherwise).

Behaviour:
- Reset outputs: busy=0, done=0, lb_we=0, attr_addr=0, spr_rom_addr=0, lb_addr=0, lb_data=0, overflow=0. FSM goes to IDLE.
- Attribute layout per sprite:
  - byte0 = Y top
  - byte1 = code
  - byte2 = {flipy, flipx, 3'b0, colour[2:0]}
  - byte3 = X left
- States:
  - IDLE: start → ATTR, idx=0. start while busy is ignored.
  - ATTR: 5 cycles. Address byte k is driven on cycle k (k=0..3); bytes are captured on cycles 1..4.
  - CHECK: 1 cycle. dy = line − Y in 8-bit modulo arithmetic. Hit when dy < 16. Hit → FETCH(half=0); miss → NEXT.
  - FETCH: drive spr_rom_addr for one cycle.
    - row = flipy ? 15−dy : dy.
    - Address half = flipx ? ~half : half.
  - FWAIT: 1 cycle. Capture spr_data1/spr_data2 into shift registers.
  - EMIT: 8 cycles, one pixel per cycle.
    - pix = {plane2 bit, plane1 bit}, taken MSB-first, or LSB-first when flipx.
    - lb_addr = X + half*8 + i, computed in 9 bits.
    - lb_we=1 only when pix≠0 AND the 9-bit sum < 256. Pixels past x=255 are clipped, not wrapped.
    - After half 0 → FETCH(half=1); after half 1 → NEXT.
  - NEXT: idx==NUM_SPR−1 → DONE; else idx+1 → ATTR.
  - DONE: done=1 for one cycle, busy→0, → IDLE.
- Cycle costs:
  - Miss: 7 cycles (ATTR+CHECK+NEXT).
  - Hit: 27 cycles (7 + 2×(1+1+8)).
  - Worst case for NUM_SPR=16: 432 cycles + DONE.
- Sprite priority: later-index writes overwrite earlier ones. The line buffer owns resolution; the block does not read the buffer back.
- Boundaries:
  - Y=250, line=4 → dy=10 → hit (vertical wrap).
  - start coinciding with DONE is ignored.
  - Reset mid-scan aborts immediately with no further lb_we.

Optional Feature:
- Macro: SPR_LINE_FETCH_OVERFLOW_EN.
- When defined:
  - A hit counter is cleared on start.
  - A CHECK hit with count==MAX_PER_LINE is treated as a miss and sets overflow.
  - overflow holds until the next accepted start.
- When undefined: no cap, overflow constant 0, no counter logic.

Decomposition:
- Shared package (spr_pkg): FSM state enum, attribute byte offsets (ATTR_Y/CODE/FLAGS/X), SPR_H=16, SPR_W=16, ROM address field widths.
- One natural sub-module: spr_pix_shift. It holds the two 8-bit plane shift registers, flip-aware bit select and the 2-bit pixel output.

Test Plan:
- Single sprite, Y=10, code=0x05, X=100, colour=3, line=12, no flip; ROM plane1=0xF0 at addr 0x0A4, plane2=0x0F → addresses 0x0A4 then 0x0A5 issued. x=100..103 get pix=1; x=104..107 get pix=2; lb_data={3,pix}. Writes at x=108..115 depend on the 0x0A5 data.
- Same sprite with flipx=1, flipy=1 → first address row=13, half=1 (0x0BB). Pixels are emitted LSB-first. The mirrored image matches a software model.
- Sprite X=250 → writes only at x=250..255 (zero pixels skipped). No lb_we for x≥256.
- All 16 sprites miss → busy for exactly 112 cycles, then a single done pulse, lb_we never asserted.
- Vertical wrap: Y=250, line=4 → hit with row 10. Y=0, line=16 → miss.
- With SPR_LINE_FETCH_OVERFLOW_EN: 10 sprites hit the same line → only the first 8 write, overflow=1. The next start clears overflow.
